// File: rtl/player_action_encoder.sv
// Per-player button front end: synchronise, debounce and edge-capture five raw
// buttons, then issue exactly one prioritised one-hot action per game tick.
module player_action_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JUMP_COOLDOWN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mirror,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_jump,
  input  logic       btn_kick,
  input  logic       btn_punch,
  output logic [5:0] action_out,
  output logic       action_valid,
  output logic       cooldown_active
);

  localparam int NBTN = 5;

  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_JUMP  = 2;
  localparam int B_KICK  = 3;
  localparam int B_PUNCH = 4;

  localparam logic [5:0] ACT_RIGHT = 6'b100000;
  localparam logic [5:0] ACT_LEFT  = 6'b010000;
  localparam logic [5:0] ACT_WAIT  = 6'b001000;
  localparam logic [5:0] ACT_JUMP  = 6'b000100;
  localparam logic [5:0] ACT_KICK  = 6'b000010;
  localparam logic [5:0] ACT_PUNCH = 6'b000001;

  // The counter has already seen DEBOUNCE_CYCLES-1 disagreeing clocks when it equals this.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] CD_LOAD  = 2'(JUMP_COOLDOWN);

  logic [NBTN-1:0]       raw_btn;

  logic [NBTN-1:0]       sync1_q, sync1_d;
  logic [NBTN-1:0]       sync2_q, sync2_d;
  logic [NBTN-1:0][7:0]  deb_cnt_q, deb_cnt_d;
  logic [NBTN-1:0]       deb_lvl_q, deb_lvl_d;
  logic [NBTN-1:0]       pend_q, pend_d;
  logic [1:0]            cd_q, cd_d;
  logic [5:0]            action_q, action_d;
  logic                  valid_q, valid_d;

  logic [NBTN-1:0]       rise;
  logic [NBTN-1:0]       cand;
  logic [5:0]            act_sel;
  logic [5:0]            act_mirrored;

  assign raw_btn = {btn_punch, btn_kick, btn_jump, btn_left, btn_right};

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync1_d   = raw_btn;
    sync2_d   = sync1_q;
    deb_cnt_d = deb_cnt_q;
    deb_lvl_d = deb_lvl_q;
    for (int i = 0; i < NBTN; i++) begin
      if (sync2_q[i] == deb_lvl_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_lvl_d[i] = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
      end
    end
  end

  // A debounced press is visible the same clock it happens, so a press landing
  // on the tick clock is consumed immediately rather than carried forward.
  assign rise = deb_lvl_d & ~deb_lvl_q;

  // ---------------------------------------------------------------------------
  // Candidate selection
  // ---------------------------------------------------------------------------
  always_comb begin
    cand         = pend_q | rise;
    cand[B_RIGHT] = cand[B_RIGHT] | deb_lvl_q[B_RIGHT];
    cand[B_LEFT]  = cand[B_LEFT]  | deb_lvl_q[B_LEFT];
    if (cand[B_RIGHT] && cand[B_LEFT]) begin
      cand[B_RIGHT] = 1'b0;
      cand[B_LEFT]  = 1'b0;
    end
    if (cd_q != 2'd0) begin
      cand[B_JUMP] = 1'b0;
    end
  end

  always_comb begin
    act_sel = ACT_WAIT;
    if (cand[B_PUNCH]) begin
      act_sel = ACT_PUNCH;
    end else if (cand[B_KICK]) begin
      act_sel = ACT_KICK;
    end else if (cand[B_JUMP]) begin
      act_sel = ACT_JUMP;
    end else if (cand[B_RIGHT]) begin
      act_sel = ACT_RIGHT;
    end else if (cand[B_LEFT]) begin
      act_sel = ACT_LEFT;
    end
  end

  // Mirroring only relabels direction after priority has been resolved.
  always_comb begin
    act_mirrored = act_sel;
    if (mirror) begin
      case (act_sel)
        ACT_RIGHT: act_mirrored = ACT_LEFT;
        ACT_LEFT:  act_mirrored = ACT_RIGHT;
        default:   act_mirrored = act_sel;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tick-time updates: output, pending latches, cooldown
  // ---------------------------------------------------------------------------
  always_comb begin
    action_d = action_q;
    valid_d  = tick;
    pend_d   = pend_q | rise;
    cd_d     = cd_q;
    if (tick) begin
      action_d = act_mirrored;
      pend_d   = '0;
      if (act_sel == ACT_JUMP) begin
        cd_d = CD_LOAD;
      end else if (cd_q != 2'd0) begin
        cd_d = cd_q - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the per-button counter array is ordinary flop storage, so it is
  // cleared by reset along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_cnt_q <= '0;
      deb_lvl_q <= '0;
      pend_q    <= '0;
      cd_q      <= '0;
      action_q  <= ACT_WAIT;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_cnt_q <= deb_cnt_d;
      deb_lvl_q <= deb_lvl_d;
      pend_q    <= pend_d;
      cd_q      <= cd_d;
      action_q  <= action_d;
      valid_q   <= valid_d;
    end
  end

  assign action_out      = action_q;
  assign action_valid    = valid_q;
  assign cooldown_active = (cd_q != 2'd0);

endmodule

// File: tb/tb_player_action_encoder.sv
// Directed and randomised bench for player_action_encoder, checked every clock
// against a behavioural model built from the button/tick rules.
module tb_player_action_encoder;

  localparam int DEB = 4;
  localparam int CD  = 2;

  localparam logic [5:0] A_RIGHT = 6'b100000;
  localparam logic [5:0] A_LEFT  = 6'b010000;
  localparam logic [5:0] A_WAIT  = 6'b001000;
  localparam logic [5:0] A_JUMP  = 6'b000100;
  localparam logic [5:0] A_KICK  = 6'b000010;
  localparam logic [5:0] A_PUNCH = 6'b000001;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       mirror;
  logic       btn_right, btn_left, btn_jump, btn_kick, btn_punch;
  logic [5:0] action_out;
  logic       action_valid;
  logic       cooldown_active;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  player_action_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .JUMP_COOLDOWN  (CD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .mirror         (mirror),
    .btn_right      (btn_right),
    .btn_left       (btn_left),
    .btn_jump       (btn_jump),
    .btn_kick       (btn_kick),
    .btn_punch      (btn_punch),
    .action_out     (action_out),
    .action_valid   (action_valid),
    .cooldown_active(cooldown_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Button vector order: [0]right [1]left [2]jump [3]kick [4]punch
  // ---------------------------------------------------------------------------
  logic [4:0] m_seen1, m_seen2;   // raw samples one and two clocks ago
  logic [4:0] m_lvl, m_pend;
  int         m_run [5];          // length of the current disagreement run
  int         m_cd;
  logic [5:0] m_action;
  logic       m_valid;

  function automatic logic [5:0] code_of(input int b);
    case (b)
      0:       return A_RIGHT;
      1:       return A_LEFT;
      2:       return A_JUMP;
      3:       return A_KICK;
      4:       return A_PUNCH;
      default: return A_WAIT;
    endcase
  endfunction

  task automatic model_reset();
    m_seen1  = '0;
    m_seen2  = '0;
    m_lvl    = '0;
    m_pend   = '0;
    m_cd     = 0;
    m_action = A_WAIT;
    m_valid  = 1'b0;
    for (int b = 0; b < 5; b++) m_run[b] = 0;
  endtask

  task automatic model_step();
    logic [4:0] raw, rose, cand, old_lvl;
    int         prio [5];
    int         pick;
    logic [5:0] act;
    prio    = '{4, 3, 2, 0, 1};
    raw     = {btn_punch, btn_kick, btn_jump, btn_left, btn_right};
    old_lvl = m_lvl;
    rose    = '0;
    for (int b = 0; b < 5; b++) begin
      if (m_seen2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = m_seen2[b];
          m_run[b] = 0;
          rose[b]  = m_lvl[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_seen2 = m_seen1;
    m_seen1 = raw;
    m_valid = tick;
    if (tick) begin
      cand = m_pend | rose | (old_lvl & 5'b00011);
      if (cand[0] && cand[1]) cand[1:0] = 2'b00;
      if (m_cd > 0) cand[2] = 1'b0;
      pick = -1;
      for (int k = 0; k < 5; k++) begin
        if (pick < 0 && cand[prio[k]]) pick = prio[k];
      end
      act = code_of(pick);
      if (pick == 2)     m_cd = CD;
      else if (m_cd > 0) m_cd = m_cd - 1;
      if (mirror && pick == 0) act = A_LEFT;
      if (mirror && pick == 1) act = A_RIGHT;
      m_action = act;
      m_pend   = '0;
    end else begin
      m_pend = m_pend | rose;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cyc_action",   32'(action_out),      32'(m_action));
      check("cyc_valid",    32'(action_valid),    32'(m_valid));
      check("cyc_cooldown", 32'(cooldown_active), 32'(m_cd > 0));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick(input string tag, input logic [5:0] exp);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check(tag, 32'(action_out), 32'(exp));
    check({tag, "_valid"}, 32'(action_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_action"},   32'(action_out),      32'(A_WAIT));
    check({tag, "_valid"},    32'(action_valid),    32'd0);
    check({tag, "_cooldown"}, 32'(cooldown_active), 32'd0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mirror = 1'b0;
    btn_right = 1'b0; btn_left = 1'b0; btn_jump = 1'b0; btn_kick = 1'b0; btn_punch = 1'b0;
    wait_clk(3);
    check_reset_outputs("reset_init");
    rst = 1'b0;
    chk_en = 1'b1;
    wait_clk(1);
    do_tick("first_tick_idle", A_WAIT);

    // Debounce filtering
    btn_punch = 1'b1; wait_clk(3); btn_punch = 1'b0; wait_clk(10);
    do_tick("glitch_3clk", A_WAIT);
    btn_punch = 1'b1; wait_clk(10);
    do_tick("punch_held", A_PUNCH);
    wait_clk(1);
    check("valid_one_clk", 32'(action_valid), 32'd0);
    check("action_holds",  32'(action_out),   32'(A_PUNCH));

    // Edge-only attacks
    do_tick("held_tick2", A_WAIT);
    wait_clk(3);
    do_tick("held_tick3", A_WAIT);
    btn_punch = 1'b0; wait_clk(10);
    btn_punch = 1'b1; wait_clk(10);
    do_tick("repress", A_PUNCH);
    btn_punch = 1'b0; wait_clk(10);

    // Priority and cancellation
    btn_punch = 1'b1; btn_kick = 1'b1; wait_clk(10);
    do_tick("punch_over_kick", A_PUNCH);
    btn_punch = 1'b0; btn_kick = 1'b0; wait_clk(10);
    do_tick("kick_dropped", A_WAIT);
    btn_right = 1'b1; btn_left = 1'b1; wait_clk(10);
    do_tick("rl_cancel", A_WAIT);
    btn_kick = 1'b1; wait_clk(10);
    do_tick("rl_kick", A_KICK);
    btn_right = 1'b0; btn_left = 1'b0; btn_kick = 1'b0; wait_clk(10);
    do_tick("release_all", A_WAIT);

    // Jump cooldown
    btn_jump = 1'b1; wait_clk(10);
    do_tick("jump_t1", A_JUMP);
    check("cooldown_t1", 32'(cooldown_active), 32'd1);
    btn_jump = 1'b0; wait_clk(10);
    btn_jump = 1'b1; btn_right = 1'b1; wait_clk(10);
    do_tick("jump_masked_t2", A_RIGHT);
    check("cooldown_t2", 32'(cooldown_active), 32'd1);
    btn_jump = 1'b0; wait_clk(10);
    btn_jump = 1'b1; wait_clk(10);
    do_tick("jump_masked_t3", A_RIGHT);
    check("cooldown_t3", 32'(cooldown_active), 32'd0);
    btn_jump = 1'b0; btn_right = 1'b0; wait_clk(10);
    btn_jump = 1'b1; wait_clk(10);
    do_tick("jump_t4", A_JUMP);
    btn_jump = 1'b0; wait_clk(10);
    do_tick("b2b_tick1", A_WAIT);
    do_tick("b2b_tick2", A_WAIT);
    check("cooldown_expired", 32'(cooldown_active), 32'd0);

    // Mirror and short presses
    btn_right = 1'b1; wait_clk(10);
    mirror = 1'b1;
    do_tick("mirror_on", A_LEFT);
    mirror = 1'b0;
    do_tick("mirror_off", A_RIGHT);
    btn_right = 1'b0; wait_clk(10);
    btn_punch = 1'b1; wait_clk(6); btn_punch = 1'b0; wait_clk(20);
    do_tick("short_press_kept", A_PUNCH);

    // Asynchronous reset with a pending press outstanding
    btn_punch = 1'b1; wait_clk(10); btn_punch = 1'b0; wait_clk(2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    do_tick("after_reset", A_WAIT);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        tick = 1'b0;
        #3 rst = 1'b1;
        #1 check_reset_outputs("reset_rand");
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 9) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 9) == 0) btn_jump  = ~btn_jump;
      if ($urandom_range(0, 9) == 0) btn_kick  = ~btn_kick;
      if ($urandom_range(0, 9) == 0) btn_punch = ~btn_punch;
      if ($urandom_range(0, 29) == 0) mirror = ~mirror;
      tick = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    tick = 1'b0;
    wait_clk(2);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
